// File: rtl/sdhci_cmd_ctrl.sv
// SD command-line sequencer: sends 48-bit CRC7 command frames and captures/checks responses.
// Defining SDHCI_CMD_ABORT_EN adds an abort_i input that returns the sequencer to IDLE.
module sdhci_cmd_ctrl #(
    parameter int ClkDivWidth = 8,
    parameter int RespTimeout = 64,
    parameter int GapCycles   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
`ifdef SDHCI_CMD_ABORT_EN
    input  logic                   abort_i,
`endif
    input  logic [5:0]             cmd_index_i,
    input  logic [31:0]            cmd_arg_i,
    input  logic [1:0]             resp_type_i,
    input  logic [ClkDivWidth-1:0] clk_div_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_err_o,
    output logic                   crc_err_o,
    output logic                   end_err_o,
    output logic                   index_err_o,
    output logic [127:0]           resp_o,
    output logic                   sd_clk_o,
    output logic                   sd_cmd_o,
    output logic                   sd_cmd_oe_o,
    input  logic                   sd_cmd_i
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;

    localparam logic [15:0] TimeoutLast = 16'(RespTimeout - 1);
    localparam logic [15:0] GapLast     = 16'(GapCycles - 1);

    state_t                 state, state_nxt;
    logic [ClkDivWidth-1:0] div_cnt;
    logic                   sd_clk, wrap, rise_tick, fall_tick;
    logic [15:0]            cnt, recv_last_idx;
    logic [47:0]            tx_frame, tx_sr;
    logic [126:0]           rx_sr;
    logic [127:0]           rx_full;
    logic [47:0]            rx_frame;
    logic [5:0]             idx_q;
    logic [1:0]             type_q;
    logic                   oe_q, cmd_q, abort_hit;
    logic                   send_done, wait_start, wait_tmo, recv_last, gap_done;

    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = bits[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return crc;
    endfunction

`ifdef SDHCI_CMD_ABORT_EN
    assign abort_hit = abort_i && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Free-running SD clock; >= lets a shrinking divider wrap promptly.
    assign wrap      = (div_cnt >= clk_div_i);
    assign rise_tick = wrap & ~sd_clk;
    assign fall_tick = wrap & sd_clk;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tx_frame      = {2'b01, cmd_index_i, cmd_arg_i, crc7({2'b01, cmd_index_i, cmd_arg_i}), 1'b1};
    assign rx_full       = {rx_sr, sd_cmd_i};
    assign rx_frame      = rx_full[47:0];
    assign recv_last_idx = (type_q == 2'b10) ? 16'd134 : 16'd46;

    assign send_done  = (state == SEND) && fall_tick && (cnt == 16'd48);
    assign wait_start = (state == WAIT) && rise_tick && !sd_cmd_i;
    assign wait_tmo   = (state == WAIT) && rise_tick && sd_cmd_i && (cnt == TimeoutLast);
    assign recv_last  = (state == RECV) && rise_tick && (cnt == recv_last_idx);
    assign gap_done   = (state == GAP)  && rise_tick && (cnt == GapLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) state_nxt = SEND;
                SEND: if (send_done) state_nxt = (type_q == 2'b00) ? GAP : WAIT;
                WAIT: begin
                    if (wait_start)    state_nxt = RECV;
                    else if (wait_tmo) state_nxt = GAP;
                end
                RECV: if (recv_last) state_nxt = GAP;
                GAP:  if (gap_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // cnt is per-state: bits sent, rise ticks waited, bits received after start, gap ticks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt           <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            idx_q         <= '0;
            type_q        <= '0;
            oe_q          <= 1'b0;
            cmd_q         <= 1'b1;
            done_o        <= 1'b0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_err_o     <= 1'b0;
            index_err_o   <= 1'b0;
            resp_o        <= '0;
        end else begin
            done_o <= gap_done && !abort_hit;

            if (state_nxt != state)
                cnt <= '0;
            else if ((state == SEND && fall_tick) || (state != IDLE && state != SEND && rise_tick))
                cnt <= cnt + 16'd1;

            if (state == IDLE && start_i) begin
                idx_q         <= cmd_index_i;
                type_q        <= resp_type_i;
                tx_sr         <= tx_frame;
                timeout_err_o <= 1'b0;
                crc_err_o     <= 1'b0;
                end_err_o     <= 1'b0;
                index_err_o   <= 1'b0;
                resp_o        <= '0;
            end

            if (state_nxt != SEND) begin
                oe_q  <= 1'b0;
                cmd_q <= 1'b1;
            end else if (state == SEND && fall_tick) begin
                oe_q  <= 1'b1;
                cmd_q <= tx_sr[47];
                tx_sr <= {tx_sr[46:0], 1'b0};
            end

            if (wait_start)
                rx_sr <= '0;
            else if (state == RECV && rise_tick)
                rx_sr <= rx_full[126:0];

            if (wait_tmo && !abort_hit)
                timeout_err_o <= 1'b1;

            if (recv_last && !abort_hit) begin
                end_err_o   <= ~sd_cmd_i;
                crc_err_o   <= (type_q == 2'b01) && (crc7(rx_frame[47:8]) != rx_frame[7:1]);
                index_err_o <= (type_q == 2'b01) && (rx_frame[45:40] != idx_q);
                if (type_q == 2'b10) resp_o <= {8'h00, rx_full[127:8]};
                else                 resp_o <= {96'h0, rx_frame[39:8]};
            end
        end
    end

    always_comb begin
        busy_o      = (state != IDLE);
        sd_cmd_oe_o = oe_q;
        sd_cmd_o    = cmd_q;
        sd_clk_o    = sd_clk;
    end

endmodule
